// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared widths and encodings for the MULDIV/ALU adder arbiter
package ex_muldiv_pkg;
  localparam int ADDER_W = 35;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_e;
  typedef enum logic {OWN_ALU = 1'b0, OWN_MDV = 1'b1} owner_e;
endpackage

// File: rtl/ex_muldiv_lock_wdog.sv
// ex_muldiv_lock_wdog: lock hold counter, watchdog expiry and sticky error flag
module ex_muldiv_lock_wdog #(
  parameter int MAX_LOCK = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic lock,
  input  logic exit_evt,
  output logic expire,
  output logic lock_err
);
  logic [5:0] lock_cnt_q, lock_cnt_d;
  logic lock_err_q, lock_err_d;
  always_comb begin
    expire = lock & ~exit_evt & (lock_cnt_q == 6'(MAX_LOCK - 1));
    lock_cnt_d = clr ? 6'd0 : (lock && lock_cnt_q != 6'h3f) ? lock_cnt_q + 6'd1 : lock_cnt_q;
    lock_err_d = lock_err_q | expire;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
    end
  end
  assign lock_err = lock_err_q;
endmodule

// File: rtl/ex_muldiv_dpath_arb.sv
// ex_muldiv_dpath_arb: shares the execution adder between ALU and MULDIV with a MULDIV lock
module ex_muldiv_dpath_arb
  import ex_muldiv_pkg::*;
#(
  parameter int ADDER_W  = ex_muldiv_pkg::ADDER_W,
  parameter int MAX_LOCK = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_req_valid,
  output logic               alu_req_ready,
  input  logic [ADDER_W-1:0] alu_req_op1,
  input  logic [ADDER_W-1:0] alu_req_op2,
  input  logic               alu_req_add,
  input  logic               alu_req_sub,
  output logic [ADDER_W-1:0] alu_res,
  input  logic               muldiv_req_valid,
  output logic               muldiv_req_ready,
  input  logic [ADDER_W-1:0] muldiv_req_op1,
  input  logic [ADDER_W-1:0] muldiv_req_op2,
  input  logic               muldiv_req_add,
  input  logic               muldiv_req_sub,
  input  logic               muldiv_req_last,
  output logic [ADDER_W-1:0] muldiv_res,
  input  logic               flush_pulse,
  output logic [ADDER_W-1:0] dp_op1,
  output logic [ADDER_W-1:0] dp_op2,
  output logic               dp_add,
  output logic               dp_sub,
  input  logic [ADDER_W-1:0] dp_res,
  output logic               dp_owner,
  output logic               mdv_locked,
  output logic               lock_err
);
  arb_state_e state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic in_lock, mdv_ok, g_mdv, g_alu, exit_evt, expire, clr;
  always_comb begin
    in_lock = state_q == ARB_LOCK;
    mdv_ok = rst_n & muldiv_req_valid & ~flush_pulse;
    g_mdv = mdv_ok & (in_lock | ~alu_req_valid | ~last_grant_q);
    g_alu = rst_n & ~in_lock & alu_req_valid & ~g_mdv;
    exit_evt = flush_pulse | (g_mdv & muldiv_req_last);
    clr = ~in_lock & g_mdv & ~muldiv_req_last;
    state_d = in_lock ? ((exit_evt | expire) ? ARB_IDLE : ARB_LOCK) : (clr ? ARB_LOCK : ARB_IDLE);
    last_grant_d = g_mdv ? 1'b1 : g_alu ? 1'b0 : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
    end
  end
  ex_muldiv_lock_wdog #(.MAX_LOCK(MAX_LOCK)) u_wdog (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .lock(in_lock),
    .exit_evt(exit_evt),
    .expire(expire),
    .lock_err(lock_err)
  );
  assign alu_req_ready = g_alu;
  assign muldiv_req_ready = g_mdv;
  assign dp_op1 = g_mdv ? muldiv_req_op1 : g_alu ? alu_req_op1 : '0;
  assign dp_op2 = g_mdv ? muldiv_req_op2 : g_alu ? alu_req_op2 : '0;
  assign dp_add = g_mdv ? muldiv_req_add : g_alu & alu_req_add;
  assign dp_sub = g_mdv ? muldiv_req_sub : g_alu & alu_req_sub;
  assign dp_owner = g_mdv ? OWN_MDV : OWN_ALU;
  assign mdv_locked = in_lock;
  assign alu_res = dp_res;
  assign muldiv_res = dp_res;
endmodule

// File: tb/tb_ex_muldiv_dpath_arb.sv
// tb_ex_muldiv_dpath_arb: vector, corner-sequence and random checks of the adder arbiter
module tb_ex_muldiv_dpath_arb;
  localparam int W = 35;
  localparam int ML = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_req_valid = 1'b0, alu_req_ready, alu_req_add = 1'b0, alu_req_sub = 1'b0;
  logic [W-1:0] alu_req_op1 = '0, alu_req_op2 = '0, alu_res;
  logic muldiv_req_valid = 1'b0, muldiv_req_ready, muldiv_req_add = 1'b0, muldiv_req_sub = 1'b0;
  logic muldiv_req_last = 1'b0;
  logic [W-1:0] muldiv_req_op1 = '0, muldiv_req_op2 = '0, muldiv_res;
  logic flush_pulse = 1'b0;
  logic [W-1:0] dp_op1, dp_op2, dp_res = '0;
  logic dp_add, dp_sub, dp_owner, mdv_locked, lock_err;
  int tests = 0;
  int fails = 0;
  bit m_locked = 0, m_last_mdv = 0, m_err = 0;
  int m_held = 0;
  logic s_ar, s_mr, s_lk, s_err;
  logic [W-1:0] s_op1;
  typedef struct {
    logic r, a, m, l, f;
    logic ar, mr, lk;
  } vec_t;
  vec_t tv[12];
  ex_muldiv_dpath_arb #(.ADDER_W(W), .MAX_LOCK(ML)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_req_valid(alu_req_valid),
    .alu_req_ready(alu_req_ready),
    .alu_req_op1(alu_req_op1),
    .alu_req_op2(alu_req_op2),
    .alu_req_add(alu_req_add),
    .alu_req_sub(alu_req_sub),
    .alu_res(alu_res),
    .muldiv_req_valid(muldiv_req_valid),
    .muldiv_req_ready(muldiv_req_ready),
    .muldiv_req_op1(muldiv_req_op1),
    .muldiv_req_op2(muldiv_req_op2),
    .muldiv_req_add(muldiv_req_add),
    .muldiv_req_sub(muldiv_req_sub),
    .muldiv_req_last(muldiv_req_last),
    .muldiv_res(muldiv_res),
    .flush_pulse(flush_pulse),
    .dp_op1(dp_op1),
    .dp_op2(dp_op2),
    .dp_add(dp_add),
    .dp_sub(dp_sub),
    .dp_res(dp_res),
    .dp_owner(dp_owner),
    .mdv_locked(mdv_locked),
    .lock_err(lock_err)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic cyc(input logic r, input logic a, input logic m, input logic l, input logic f);
    logic ga, gm;
    logic [W-1:0] e_op1, e_op2;
    logic e_add, e_sub;
    rst_n = r;
    alu_req_valid = a;
    muldiv_req_valid = m;
    muldiv_req_last = l;
    flush_pulse = f;
    alu_req_op1 = rnd_w();
    alu_req_op2 = rnd_w();
    muldiv_req_op1 = rnd_w();
    muldiv_req_op2 = rnd_w();
    alu_req_add = 1'($urandom);
    alu_req_sub = ~alu_req_add;
    muldiv_req_add = 1'($urandom);
    muldiv_req_sub = ~muldiv_req_add;
    dp_res = rnd_w();
    @(negedge clk);
    ga = 1'b0;
    gm = 1'b0;
    if (r) begin
      if (m_locked) gm = m && !f;
      else if (a && m && !f) begin
        gm = !m_last_mdv;
        ga = m_last_mdv;
      end else begin
        ga = a;
        gm = m && !f;
      end
    end
    e_op1 = gm ? muldiv_req_op1 : ga ? alu_req_op1 : '0;
    e_op2 = gm ? muldiv_req_op2 : ga ? alu_req_op2 : '0;
    e_add = gm ? muldiv_req_add : ga ? alu_req_add : 1'b0;
    e_sub = gm ? muldiv_req_sub : ga ? alu_req_sub : 1'b0;
    chk("alu_ready", alu_req_ready, ga);
    chk("mdv_ready", muldiv_req_ready, gm);
    chk("mdv_locked", mdv_locked, m_locked);
    chk("lock_err", lock_err, m_err);
    chk("dp_op1", dp_op1, e_op1);
    chk("dp_op2", dp_op2, e_op2);
    chk("dp_add", dp_add, e_add);
    chk("dp_sub", dp_sub, e_sub);
    if (ga || gm) chk("dp_owner", dp_owner, gm);
    chk("alu_res", alu_res, dp_res);
    chk("mdv_res", muldiv_res, dp_res);
    s_ar = alu_req_ready;
    s_mr = muldiv_req_ready;
    s_lk = mdv_locked;
    s_err = lock_err;
    s_op1 = dp_op1;
    if (!r) begin
      m_locked = 0;
      m_last_mdv = 0;
      m_held = 0;
      m_err = 0;
    end else begin
      if (m_locked) begin
        m_held++;
        if (f || (gm && l)) m_locked = 0;
        else if (m_held == ML) begin
          m_locked = 0;
          m_err = 1;
        end
      end else if (gm && !l) begin
        m_locked = 1;
        m_held = 0;
      end
      if (gm) m_last_mdv = 1;
      else if (ga) m_last_mdv = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 1, 1, 1, 0, 0, 1, 0};
    tv[2]  = '{1, 1, 1, 1, 0, 1, 0, 0};
    tv[3]  = '{1, 0, 1, 0, 0, 0, 1, 0};
    tv[4]  = '{1, 1, 0, 0, 0, 0, 0, 1};
    tv[5]  = '{1, 1, 1, 1, 1, 0, 0, 1};
    tv[6]  = '{1, 1, 1, 0, 0, 1, 0, 0};
    tv[7]  = '{1, 0, 1, 0, 1, 0, 0, 0};
    tv[8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
    tv[9]  = '{1, 1, 1, 0, 0, 0, 1, 0};
    tv[10] = '{1, 1, 1, 1, 0, 0, 1, 1};
    tv[11] = '{1, 1, 1, 1, 0, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].r, tv[i].a, tv[i].m, tv[i].l, tv[i].f);
      chk($sformatf("vec%0d_alu_ready", i), s_ar, tv[i].ar);
      chk($sformatf("vec%0d_mdv_ready", i), s_mr, tv[i].mr);
      chk($sformatf("vec%0d_locked", i), s_lk, tv[i].lk);
    end
    cyc(1, 1, 1, 0, 0);
    chk("lock17_enter", s_mr, 1);
    repeat (16) begin
      cyc(1, 1, 1, 0, 0);
      chk("lock17_alu_blocked", s_ar, 0);
      chk("lock17_locked", s_lk, 1);
    end
    cyc(1, 1, 1, 1, 0);
    chk("lock17_last_grant", s_mr, 1);
    chk("lock17_last_alu", s_ar, 0);
    cyc(1, 1, 1, 1, 0);
    chk("lock17_alu_after", s_ar, 1);
    chk("lock17_idle_after", s_lk, 0);
    cyc(1, 0, 1, 0, 0);
    repeat (5) begin
      cyc(1, 1, 0, 0, 0);
      chk("hold_locked", s_lk, 1);
      chk("hold_alu_ready", s_ar, 0);
      chk("hold_dp_op1", s_op1, 0);
    end
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0);
    repeat (9) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 1);
    chk("flush_mdv_ready", s_mr, 0);
    chk("flush_still_locked", s_lk, 1);
    cyc(1, 0, 0, 0, 0);
    chk("flush_idle", s_lk, 0);
    chk("flush_no_err", s_err, 0);
    cyc(1, 0, 1, 0, 0);
    repeat (ML - 1) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    chk("wdog_tie_last_grant", s_mr, 1);
    cyc(1, 0, 0, 0, 0);
    chk("wdog_tie_idle", s_lk, 0);
    chk("wdog_tie_no_err", s_err, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    chk("rst_lock_alu_ready", s_ar, 0);
    chk("rst_lock_mdv_ready", s_mr, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_lock_idle", s_lk, 0);
    chk("rst_lock_alu_idle", s_ar, 0);
    chk("rst_lock_mdv_idle", s_mr, 0);
    cyc(1, 1, 1, 1, 0);
    chk("rst_lock_mdv_first", s_mr, 1);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < ML; i++) begin
      cyc(1, 0, 1, 0, 0);
      chk("wdog_locked", s_lk, 1);
    end
    cyc(1, 0, 0, 0, 0);
    chk("wdog_forced_idle", s_lk, 0);
    chk("wdog_err_set", s_err, 1);
    repeat (3) begin
      cyc(1, 1, 1, 1, 0);
      chk("wdog_err_sticky", s_err, 1);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("wdog_err_cleared", s_err, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 97) != 0, 1'($urandom), ($urandom % 4) != 0,
          ($urandom % 40) == 0, ($urandom % 24) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
